// File: rtl/uart_pkg.sv
// Shared encodings, FSM state type and bit-period helper for the UART transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  // Bit period in clocks, rounded to the nearest integer.
  function automatic int calc_bit_period(input int freq, input int baudrate);
    return (freq + baudrate / 2) / baudrate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is always visible on RDATA.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           CLOCK_50M,
  input  logic                           RESET_N,
  input  logic                           WR,
  input  logic [WIDTH-1:0]               WDATA,
  input  logic                           RD,
  output logic [WIDTH-1:0]               RDATA,
  output logic                           FULL,
  output logic                           EMPTY,
  output logic [$clog2(DEPTH+1)-1:0]     LEVEL
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             push;
  logic             pop;

  assign FULL  = (level_q == LW'(DEPTH));
  assign EMPTY = (level_q == '0);
  assign LEVEL = level_q;
  assign RDATA = mem_q[rptr_q];

  // Full blocks a write even when a pop happens in the same cycle.
  assign push = WR && !FULL;
  assign pop  = RD && !EMPTY;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge CLOCK_50M) begin
    if (push) mem_q[wptr_q] <= WDATA;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FWFT FIFO; frames go out back-to-back while data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FREQ       = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                CLOCK_50M,
  input  logic                                RESET_N,
  input  logic                                WR,
  input  logic [DATA_BITS-1:0]                WDATA,
  output logic                                FULL,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     LEVEL,
  output logic                                OVERFLOW,
  output logic                                TX,
  output logic                                IDLE
);

  localparam int T  = calc_bit_period(FREQ, BAUDRATE);
  localparam int CW = (T < 2) ? 1 : $clog2(T);

  if (T < 2) begin : g_bad_period
    $error("uart_tx_fifo: bit period must be at least 2 clocks");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        clk_q, clk_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q;
  logic                 pop;
  logic                 bit_end;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50M (CLOCK_50M),
    .RESET_N   (RESET_N),
    .WR        (WR),
    .WDATA     (WDATA),
    .RD        (pop),
    .RDATA     (fifo_rdata),
    .FULL      (fifo_full),
    .EMPTY     (fifo_empty),
    .LEVEL     (LEVEL)
  );

  assign FULL     = fifo_full;
  assign OVERFLOW = ovf_q;
  assign TX       = tx_q;
  assign IDLE     = (state_q == S_IDLE) && fifo_empty;
  assign bit_end  = (clk_q == CW'(T - 1));

  always_comb begin
    state_d = state_q;
    clk_d   = clk_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          clk_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          clk_d = '0;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          clk_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          clk_d = '0;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next start bit when more data is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        clk_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
    if (pop) begin
      shreg_d = fifo_rdata;
      par_d   = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
    end
  end

  always_ff @(posedge CLOCK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      clk_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ovf_q   <= WR && fifo_full;
    end
  end

  always_ff @(posedge CLOCK_50M) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations sharing one clock and reset.
module tb_uart_tx_fifo;

  localparam int T = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] wr;
  logic [7:0] wd_a, wd_c, wd_d;
  logic [6:0] wd_b;
  logic [3:0] tx_w, idle_w, full_w, ovf_w;
  logic [4:0] lvl_a, lvl_b, lvl_c;
  logic [2:0] lvl_d;
  logic [4:0] lvl_w [4];

  assign lvl_w[0] = lvl_a;
  assign lvl_w[1] = lvl_b;
  assign lvl_w[2] = lvl_c;
  assign lvl_w[3] = {2'b00, lvl_d};

  uart_tx_fifo #(.FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
    .CLOCK_50M(clk), .RESET_N(rst_n), .WR(wr[0]), .WDATA(wd_a), .FULL(full_w[0]),
    .LEVEL(lvl_a), .OVERFLOW(ovf_w[0]), .TX(tx_w[0]), .IDLE(idle_w[0]));

  uart_tx_fifo #(.FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
    .CLOCK_50M(clk), .RESET_N(rst_n), .WR(wr[1]), .WDATA(wd_b), .FULL(full_w[1]),
    .LEVEL(lvl_b), .OVERFLOW(ovf_w[1]), .TX(tx_w[1]), .IDLE(idle_w[1]));

  uart_tx_fifo #(.FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut_c (
    .CLOCK_50M(clk), .RESET_N(rst_n), .WR(wr[2]), .WDATA(wd_c), .FULL(full_w[2]),
    .LEVEL(lvl_c), .OVERFLOW(ovf_w[2]), .TX(tx_w[2]), .IDLE(idle_w[2]));

  uart_tx_fifo #(.FREQ(1_000_000), .BAUDRATE(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_d (
    .CLOCK_50M(clk), .RESET_N(rst_n), .WR(wr[3]), .WDATA(wd_d), .FULL(full_w[3]),
    .LEVEL(lvl_d), .OVERFLOW(ovf_w[3]), .TX(tx_w[3]), .IDLE(idle_w[3]));

  int n_checks = 0;
  int n_fail   = 0;

  // Line recorder for the depth-4 instance and frame decoder for the 8N1 instance.
  logic       rec_en = 1'b0;
  logic       rec_tx [$];
  logic       hunt = 1'b1;
  int         dcnt = 0;
  logic [7:0] dbyte = '0;
  logic [7:0] decoded [$];
  int         frame_err = 0;

  typedef struct {
    int         k;
    logic [7:0] data;
    string      bits;
    string      name;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rec_en) rec_tx.push_back(tx_w[3]);
    if (hunt) begin
      if (tx_w[0] == 1'b0) begin
        hunt = 1'b0;
        dcnt = 0;
      end
    end else begin
      dcnt++;
      if (dcnt >= 15 && dcnt <= 85 && (dcnt % 10) == 5) dbyte = {tx_w[0], dbyte[7:1]};
      if (dcnt == 95) begin
        if (tx_w[0] === 1'b1) decoded.push_back(dbyte);
        else frame_err++;
      end
      if (dcnt == 99) hunt = 1'b1;
    end
  endtask

  task automatic set_wr(input int k, input logic en, input logic [7:0] d);
    wr[k] = en;
    case (k)
      0:       wd_a = d;
      1:       wd_b = d[6:0];
      2:       wd_c = d;
      default: wd_d = d;
    endcase
  endtask

  function automatic logic model_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic send_frame(input int k, input logic [7:0] data, input string exp, input string name);
    int good;
    logic e;
    set_wr(k, 1'b1, data);
    tick();
    set_wr(k, 1'b0, 8'h00);
    check({name, " tx high 1 clk after WR"}, tx_w[k], 1);
    check({name, " idle low after write"}, idle_w[k], 0);
    check({name, " level after write"}, lvl_w[k], 1);
    for (int i = 0; i < exp.len(); i++) begin
      e = (exp[i] == "1");
      good = 0;
      for (int j = 0; j < T; j++) begin
        tick();
        if (tx_w[k] === e) good++;
      end
      check($sformatf("%s line bit %0d clocks correct", name, i), good, T);
    end
    check({name, " idle low in last stop clock"}, idle_w[k], 0);
    tick();
    check({name, " idle high after stop"}, idle_w[k], 1);
    check({name, " tx idle high"}, tx_w[k], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         bad;
    int         cnt;
    int         over_lvl;
    int         max_lvl;
    logic [7:0] d;
    logic [7:0] acc [$];

    vecs[0] = '{0, 8'h41, "0100000101",  "8N1 0x41"};
    vecs[1] = '{0, 8'hA5, "0101001011",  "8N1 0xA5"};
    vecs[2] = '{1, 8'h35, "01010110011", "7E2 0x35"};
    vecs[3] = '{1, 8'h01, "01000000111", "7E2 0x01"};
    vecs[4] = '{2, 8'h00, "00000000011", "8O1 0x00"};
    vecs[5] = '{2, 8'hFF, "01111111111", "8O1 0xFF"};
    vecs[6] = '{2, 8'h01, "01000000001", "8O1 0x01"};

    rst_n = 1'b0;
    wr    = '0;
    wd_a  = '0;
    wd_b  = '0;
    wd_c  = '0;
    wd_d  = '0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset tx[%0d]", k), tx_w[k], 1);
      check($sformatf("reset idle[%0d]", k), idle_w[k], 1);
      check($sformatf("reset full[%0d]", k), full_w[k], 0);
      check($sformatf("reset level[%0d]", k), lvl_w[k], 0);
      check($sformatf("reset overflow[%0d]", k), ovf_w[k], 0);
    end
    rst_n = 1'b1;
    tick();
    tick();

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].k, vecs[v].data, vecs[v].bits, vecs[v].name);
      tick();
    end

    // Depth-4 FIFO: six consecutive writes, the sixth must be dropped.
    rec_tx.delete();
    rec_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_wr(3, 1'b1, 8'(i + 1));
      tick();
      if (i == 1) check("depth4 level with write+pop", lvl_w[3], 1);
      if (i == 4) begin
        check("depth4 level full", lvl_w[3], 4);
        check("depth4 full flag", full_w[3], 1);
        check("depth4 no overflow yet", ovf_w[3], 0);
      end
      if (i == 5) begin
        check("depth4 overflow pulse", ovf_w[3], 1);
        check("depth4 level after drop", lvl_w[3], 4);
      end
    end
    set_wr(3, 1'b0, 8'h00);
    tick();
    check("depth4 overflow one cycle", ovf_w[3], 0);
    while (rec_tx.size() < 505) tick();
    rec_en = 1'b0;
    check("depth4 line high before start", rec_tx[0], 1);
    for (int f = 0; f < 5; f++) begin
      bad = 0;
      for (int s = 0; s < 100; s++)
        if (rec_tx[1 + f*100 + s] !== model_bit(8'(f + 1), s / 10)) bad++;
      check($sformatf("depth4 frame %0d wrong clocks", f + 1), bad, 0);
    end
    bad = 0;
    for (int s = 501; s < 505; s++) if (rec_tx[s] !== 1'b1) bad++;
    check("depth4 line high after last frame", bad, 0);
    check("depth4 idle after burst", idle_w[3], 1);

    // Reset in the middle of a frame with words still queued.
    set_wr(0, 1'b1, 8'hA5); tick();
    set_wr(0, 1'b1, 8'h11); tick();
    set_wr(0, 1'b1, 8'h22); tick();
    set_wr(0, 1'b1, 8'h33); tick();
    set_wr(0, 1'b0, 8'h00);
    check("midreset level before", lvl_w[0], 3);
    for (int i = 0; i < 43; i++) tick();
    check("midreset tx at frame clock 45", tx_w[0], 0);
    rst_n = 1'b0;
    #1;
    check("midreset tx async high", tx_w[0], 1);
    check("midreset level cleared", lvl_w[0], 0);
    check("midreset idle", idle_w[0], 1);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (tx_w[0] === 1'b1 && idle_w[0] === 1'b1) cnt++;
    end
    check("post-reset line quiet clocks", cnt, 150);

    // Continuous WR stream: accepted words must all appear on the line in order.
    decoded.delete();
    hunt      = 1'b1;
    frame_err = 0;
    over_lvl  = 0;
    max_lvl   = 0;
    for (int c = 0; c < 1500; c++) begin
      d = 8'(c * 7 + 3);
      set_wr(0, 1'b1, d);
      if (full_w[0] === 1'b0) acc.push_back(d);
      tick();
      if (lvl_w[0] > 5'd16) over_lvl++;
      if (int'(lvl_w[0]) > max_lvl) max_lvl = int'(lvl_w[0]);
    end
    set_wr(0, 1'b0, 8'h00);
    cnt = 0;
    while (idle_w[0] !== 1'b1 && cnt < 5000) begin
      tick();
      cnt++;
    end
    check("stream drained to idle", idle_w[0], 1);
    for (int i = 0; i < 5; i++) tick();
    check("stream level never above depth", over_lvl, 0);
    check("stream fifo reached full", max_lvl, 16);
    check("stream transmitted count", decoded.size(), acc.size());
    bad = 0;
    for (int i = 0; i < acc.size() && i < decoded.size(); i++)
      if (decoded[i] !== acc[i]) bad++;
    check("stream data mismatches", bad, 0);
    check("stream framing errors", frame_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
